// File: rtl/fe_pkg.sv
// Shared definitions for the fetch front end: group geometry, FSM states and
// the slot-mask helper used by the response stage.
package fe_pkg;
    localparam int FETCH_W    = 4;
    localparam int PC_W       = 16;
    localparam int INSN_BYTES = 2;

    typedef enum logic [1:0] {BOOT, RUN, STALL} fe_state_e;

    function automatic logic [FETCH_W-1:0] therm_mask(input logic [2:0] cnt);
        logic [FETCH_W-1:0] m;
        m = '0;
        for (int i = 0; i < FETCH_W; i++)
            if (i < int'(cnt)) m[i] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/fetch_credit_ctr.sv
// Instruction-buffer credit tracker: occupancy (buffer + in-flight group) and
// the number of slots that may be fetched this cycle.
module fetch_credit_ctr
    import fe_pkg::*;
#(
    parameter int  IB_DEPTH = 16,
    localparam int OCC_W    = $clog2(IB_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_jump,
    input  logic [2:0]       ib_pop,
    input  logic [2:0]       fetch_cnt,
    output logic [2:0]       avail_cnt,
    output logic             full_next,
    output logic [OCC_W-1:0] occ
);
    logic [OCC_W:0]   free;
    logic [OCC_W:0]   sum;
    logic [OCC_W:0]   pop_w;
    logic [OCC_W-1:0] occ_next;

    assign free      = (OCC_W+1)'(IB_DEPTH) - {1'b0, occ};
    assign avail_cnt = (free >= (OCC_W+1)'(FETCH_W)) ? 3'(FETCH_W) : 3'(free);
    assign sum       = {1'b0, occ} + (OCC_W+1)'(fetch_cnt);
    assign pop_w     = (OCC_W+1)'(ib_pop);

    // A jump flushes the buffer and squashes the in-flight group; a pop larger
    // than what is held clamps at empty instead of wrapping.
    always_comb begin
        occ_next = '0;
        if (!is_jump && sum > pop_w) occ_next = OCC_W'(sum - pop_w);
    end

    assign full_next = (occ_next == OCC_W'(IB_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) occ <= '0;
        else     occ <= occ_next;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: issues up to four 2-byte-slot addresses per cycle to the
// icache, throttled by buffer credits and redirected by the branch unit.
module fetch_sequencer
    import fe_pkg::*;
#(
    parameter int              IB_DEPTH = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    is_jump,
    input  logic [PC_W-1:0]         jump_target,
    input  logic [2:0]              ib_pop,
    output logic [FETCH_W*PC_W-1:0] pc_to_icache_flat,
    output logic                    fetch_req,
    output logic [2:0]              fetch_cnt,
    output logic                    resp_valid,
    output logic [FETCH_W-1:0]      resp_mask
);
    localparam int OCC_W = $clog2(IB_DEPTH + 1);

    fe_state_e            state_q, state_d;
    logic [PC_W-1:0]      pc_q;
    logic [2:0]           avail_cnt;
    logic                 full_next;
    logic [OCC_W-1:0]     occ;
    logic                 rv_q;
    logic [FETCH_W-1:0]   mask_q;

    fetch_credit_ctr #(.IB_DEPTH(IB_DEPTH)) u_credit (
        .clk       (clk),
        .rst       (rst),
        .is_jump   (is_jump),
        .ib_pop    (ib_pop),
        .fetch_cnt (fetch_cnt),
        .avail_cnt (avail_cnt),
        .full_next (full_next),
        .occ       (occ)
    );

    assign fetch_cnt = (state_q == RUN) ? avail_cnt : 3'd0;
    assign fetch_req = (fetch_cnt != 3'd0) && !is_jump;

    // Leave RUN only if the buffer stays full after this cycle's pop, so a
    // returned credit shows up in fetch_cnt on the very next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (avail_cnt == 3'd0 && full_next) state_d = STALL;
            STALL:   if (!full_next) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            rv_q    <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (is_jump) pc_q <= jump_target & ~PC_W'(1);
            else         pc_q <= pc_q + PC_W'(fetch_cnt) * PC_W'(INSN_BYTES);
            rv_q    <= fetch_req;
            mask_q  <= therm_mask(fetch_cnt);
        end
    end

    assign resp_valid = rv_q && !is_jump;
    assign resp_mask  = resp_valid ? mask_q : '0;

    for (genvar g = 0; g < FETCH_W; g++) begin : g_slot
        assign pc_to_icache_flat[(FETCH_W-1-g)*PC_W +: PC_W] = pc_q + PC_W'(g * INSN_BYTES);
    end
endmodule
